// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: event-mode
// encodings and the saturation limit helper for the per-channel counters.
package edge_pkg;

  // Global event selection driven on mode_i.
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // All-ones value of a w-bit counter (w up to 64), used as the saturation point.
  function automatic logic [63:0] sat_max(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: synchroniser, glitch filter, edge pulses,
// mode-gated event, sticky pending flag and saturating event counter.
// There is no handshake here: every output is a level or a one-cycle pulse
// that is valid on every clock, and clr_i / cnt_clr_i act on the edge at
// which they are sampled high.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  input  logic             cnt_clr_i,
  output logic             rising_edge_o,
  output logic             falling_edge_o,
  output logic             edge_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt;
  logic                   filt_d_q;
  logic                   pending_q;
  logic [CNT_W-1:0]       count_q;

  // Shift the raw input through the synchroniser chain; the last stage is the sampled level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_no_filter
    // Filter bypassed: the sampled level is already a flop output.
    assign filt = s;
  end else begin : g_filter
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);

    logic [FW-1:0] fcnt_q;
    logic          filt_q;

    // Accept a new level only after it has differed from the filtered level for FILTER_CYCLES samples.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        fcnt_q <= '0;
        filt_q <= 1'b0;
      end else if (s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == LAST) begin
        filt_q <= s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end

    assign filt = filt_q;
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_d_q <= 1'b0;
    end else begin
      filt_d_q <= filt;
    end
  end

  assign rising_edge_o  = filt & ~filt_d_q;
  assign falling_edge_o = ~filt & filt_d_q;

  // Select which accepted transitions count as events; takes effect in the same cycle.
  always_comb begin
    edge_o = 1'b0;
    case (mode_i)
      MODE_RISE: edge_o = rising_edge_o;
      MODE_FALL: edge_o = falling_edge_o;
      MODE_BOTH: edge_o = rising_edge_o | falling_edge_o;
      default:   edge_o = 1'b0;
    endcase
  end

  // Sticky pending flag; a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= edge_o | (pending_q & ~clr_i);
    end
  end

  // Saturating event counter; a clear coinciding with an event leaves a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (cnt_clr_i) begin
      count_q <= edge_o ? CNT_W'(1) : '0;
    end else if (edge_o && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: NUM_CH independent channels, packed event
// counters and a single interrupt formed from all pending flags.
module multi_edge_detect #(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a_i,
  input  logic [1:0]              mode_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic                    cnt_clr_i,
  output logic [NUM_CH-1:0]       rising_edge_o,
  output logic [NUM_CH-1:0]       falling_edge_o,
  output logic [NUM_CH-1:0]       edge_o,
  output logic [NUM_CH-1:0]       pending_o,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic                    irq_o
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .a_i           (a_i[k]),
      .mode_i        (mode_i),
      .clr_i         (clr_i[k]),
      .cnt_clr_i     (cnt_clr_i),
      .rising_edge_o (rising_edge_o[k]),
      .falling_edge_o(falling_edge_o[k]),
      .edge_o        (edge_o[k]),
      .pending_o     (pending_o[k]),
      .count_o       (count_o[k*CNT_W +: CNT_W])
    );
  end

  assign irq_o = |pending_o;

endmodule
